// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter:
//   - arb_state_t : arbiter FSM encoding (IDLE=0, GRANT=1)
//   - BURST_CNT_W : width of the per-grant transfer counter
//   - clog2_min1  : ceil(log2(n)), never less than 1, for index widths
package fifo_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int BURST_CNT_W = 8;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Rotating-priority first-one finder. Searches req starting at index ptr
//   and wrapping modulo N_REQ; returns the first set index.
//   Ports:
//     req  in  N_REQ  request vector
//     ptr  in  IDW    index with highest priority
//     idx  out IDW    first requesting index at or after ptr (0 if none)
//     any  out 1      at least one request present
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  logic [IDW-1:0] w_cand;

  // Walk from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    idx    = '0;
    w_cand = '0;
    any    = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = IDW'((int'(ptr) + k) % N_REQ);
      if (req[w_cand]) idx = w_cand;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares one FIFO write port among N_REQ producers. Producers are granted
//   round-robin; a grant lasts for up to max_burst transfers or until the
//   granted producer drops its valid. Arbitration takes one IDLE cycle.
//   Data and strobes are combinational from the current grant.
//   Ports:
//     clock           in   1            clock, all state on posedge
//     reset_n         in   1            asynchronous reset, active low
//     req_valid       in   N_REQ        producer i has a word
//     req_data        in   N_REQ*width  producer i data at [i*width +: width]
//     req_rdy         out  N_REQ        producer i word accepted this cycle
//     fifo_din        out  width        data to FIFO
//     fifo_din_valid  out  1            FIFO write strobe
//     fifo_din_rdy    in   1            FIFO not full
//     grant_id        out  GW           currently granted producer
//     busy            out  1            arbiter in GRANT state
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int width     = 8,
  parameter  int max_burst = 4,
  localparam int GW        = clog2_min1(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*width-1:0] req_data,
  output logic [N_REQ-1:0]       req_rdy,
  output logic [width-1:0]       fifo_din,
  output logic                   fifo_din_valid,
  input  logic                   fifo_din_rdy,
  output logic [GW-1:0]          grant_id,
  output logic                   busy
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [GW-1:0]          r_grant;
  logic [GW-1:0]          w_grant_nxt;
  logic [GW-1:0]          r_rr_ptr;
  logic [GW-1:0]          w_rr_ptr_nxt;
  logic [BURST_CNT_W-1:0] r_burst;
  logic [BURST_CNT_W-1:0] w_burst_nxt;

  logic [GW-1:0]          w_pick_idx;
  logic                   w_pick_any;
  logic [GW-1:0]          w_grant_inc;
  logic                   w_grant_req;
  logic                   w_xfer;
  logic                   w_last;
  logic [width-1:0]       w_slice [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_slice[g] = req_data[g*width +: width];
  end

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDW   (GW)
  ) u_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_grant_req = req_valid[r_grant];
  assign w_xfer      = (r_state == ST_GRANT) & w_grant_req & fifo_din_rdy;
  assign w_last      = (r_burst == BURST_CNT_W'(max_burst - 1));
  // Explicit wrap keeps non-power-of-two N_REQ correct.
  assign w_grant_inc = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + GW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_burst_nxt  = r_burst;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick_idx;
          w_burst_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (w_xfer) begin
          w_burst_nxt = r_burst + BURST_CNT_W'(1);
          if (w_last) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = w_grant_inc;
          end
        end else if (!w_grant_req) begin
          // Producer went idle; a full FIFO alone never ends the grant.
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_grant_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_burst  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_burst  <= w_burst_nxt;
    end
  end

  assign busy           = (r_state == ST_GRANT);
  assign grant_id       = r_grant;
  assign fifo_din       = w_slice[r_grant];
  assign fifo_din_valid = w_xfer;
  assign req_rdy        = w_xfer ? (N_REQ'(1) << r_grant) : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   fifo_din;
  logic           fifo_din_valid;
  logic           fifo_din_rdy;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clock = ~clock;

  fifo_write_arbiter #(.N_REQ(N), .width(W), .max_burst(MB)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_rdy        (req_rdy),
    .fifo_din       (fifo_din),
    .fifo_din_valid (fifo_din_valid),
    .fifo_din_rdy   (fifo_din_rdy),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the FIFO port, how many words it has written
  // in this grant, and where the next search starts.
  bit           m_busy;
  int           m_owner;
  int           m_ptr;
  int           m_words;
  logic [N-1:0] m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_words = 0; m_acc = '0;
  endtask

  task automatic model_step();
    int f;
    m_acc = '0;
    if (!reset_n) begin
      model_reset();
    end else if (!m_busy) begin
      f = first_from(req_valid, m_ptr);
      if (f >= 0) begin
        m_busy = 1; m_owner = f; m_words = 0;
      end
    end else if (req_valid[m_owner] && fifo_din_rdy) begin
      m_acc[m_owner] = 1'b1;
      m_words++;
      if (m_words == MB) begin
        m_busy = 0; m_ptr = (m_owner + 1) % N;
      end
    end else if (!req_valid[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % N;
    end
  endtask

  task automatic compare_model();
    bit           strobe;
    logic [N-1:0] exp_rdy;
    strobe  = m_busy && req_valid[m_owner] && fifo_din_rdy;
    exp_rdy = strobe ? (N'(1) << m_owner) : '0;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("fifo_din_valid", 32'(fifo_din_valid), 32'(strobe));
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    if (strobe) chk("fifo_din", 32'(fifo_din), 32'(req_data[m_owner*W +: W]));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
    compare_model();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] strobe_log;
    int         nstb;
    int         cyc;
    int         more;
    bit         held;
    int         gq[$];

    // Reset with every producer requesting.
    reset_n      = 1'b0;
    req_valid    = '1;
    req_data     = '0;
    fifo_din_rdy = 1'b1;
    model_reset();
    #2;
    chk("reset_req_rdy", 32'(req_rdy), 32'h0);
    chk("reset_din_valid", 32'(fifo_din_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_grant_id", 32'(grant_id), 32'h0);
    tick();
    tick();

    // Single producer 2 with data 0xA5.
    reset_n          = 1'b1;
    req_valid        = 4'b0100;
    req_data[2*W +: W] = 8'hA5;
    settle();
    strobe_log = '0;
    nstb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      strobe_log = {strobe_log[8:0], fifo_din_valid};
      if (fifo_din_valid) nstb++;
      if (i == 0) chk("single_first_data", 32'(fifo_din), 32'hA5);
    end
    chk("single_strobe_pattern", 32'(strobe_log), 32'b1111011110);
    chk("single_strobe_count", 32'(nstb), 32'd8);
    chk("single_grant_kept", 32'(grant_id), 32'd2);

    // All producers requesting continuously.
    apply_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'hC0 + i);
    settle();
    cyc = 0;
    while (gq.size() < 20 && cyc < 60) begin
      tick();
      settle();
      cyc++;
      if (fifo_din_valid) gq.push_back(int'(grant_id));
    end
    chk("all_req_cycles_for_20", 32'(cyc), 32'd24);
    for (int k = 0; k < gq.size(); k++) chk("grant_order", 32'(gq[k]), 32'((k / 4) % 4));

    // Backpressure after two words.
    apply_reset();
    req_valid = 4'b0001;
    req_data[0 +: W] = 8'h5A;
    fifo_din_rdy = 1'b1;
    settle();
    nstb = 0;
    cyc  = 0;
    while (nstb < 2 && cyc < 20) begin
      tick();
      settle();
      cyc++;
      if (fifo_din_valid) nstb++;
    end
    chk("bp_two_words_seen", 32'(nstb), 32'd2);
    tick();
    fifo_din_rdy = 1'b0;
    settle();
    nstb = 0;
    held = 1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        tick();
        settle();
      end
      if (fifo_din_valid) nstb++;
      held = held && busy && (grant_id == 2'd0);
    end
    chk("bp_no_strobes", 32'(nstb), 32'd0);
    chk("bp_grant_held", 32'(held), 32'd1);
    tick();
    fifo_din_rdy = 1'b1;
    settle();
    more = 0;
    cyc  = 0;
    while (busy && cyc < 20) begin
      if (fifo_din_valid) more++;
      tick();
      settle();
      cyc++;
    end
    chk("bp_words_after_release", 32'(more), 32'd2);

    // Early drop by producer 1 after one word.
    apply_reset();
    req_valid = 4'b0110;
    settle();
    tick();
    settle();
    chk("drop_first_grant", 32'(grant_id), 32'd1);
    chk("drop_first_strobe", 32'(fifo_din_valid), 32'd1);
    tick();
    req_valid = 4'b0100;
    settle();
    chk("drop_no_strobe", 32'(fifo_din_valid), 32'd0);
    tick();
    settle();
    chk("drop_idle", 32'(busy), 32'd0);
    tick();
    settle();
    chk("drop_next_grant", 32'(grant_id), 32'd2);
    chk("drop_next_busy", 32'(busy), 32'd1);

    // Asynchronous reset in the middle of a grant.
    apply_reset();
    req_valid = '1;
    settle();
    tick();
    settle();
    tick();
    settle();
    chk("mid_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_req_rdy", 32'(req_rdy), 32'h0);
    chk("async_din_valid", 32'(fifo_din_valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_grant_id", 32'(grant_id), 32'h0);
    model_reset();
    tick();
    reset_n   = 1'b1;
    req_valid = 4'b1010;
    settle();
    tick();
    settle();
    chk("post_reset_grant", 32'(grant_id), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd1);

    // Randomised traffic against the model.
    apply_reset();
    req_valid = '0;
    settle();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (m_acc[i]) begin
            req_valid[i] = ($urandom_range(99) < 70);
            req_data[i*W +: W] = W'($urandom);
          end else if ($urandom_range(99) < 3) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(99) < 40) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end
      end
      fifo_din_rdy = ($urandom_range(99) < 75);
      if (c % 700 == 350) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
